// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry pipeline register between fetch and execute with
// valid/ready handshakes, a shifting load-use scoreboard and branch/jump flush.
module decode_stage #(
  parameter int ADDRESS_BITS = 16,
  parameter int SB_DEPTH     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [31:0]             in_instruction,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    branch_op,
  output logic                    op_B_sel,
  output logic [1:0]              op_A_sel,
  output logic [5:0]              ALU_Control,
  output logic [31:0]             imm32,
  output logic                    illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        hold_valid;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        in_fire;
  logic        out_fire;
  logic        sb_load_v;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [5:0]  alu_arith;

  logic [5:0]  dec_alu;
  logic [1:0]  dec_op_a;
  logic        dec_op_b;
  logic [31:0] dec_imm;
  logic        dec_wen;
  logic        dec_mem_wen;
  logic        dec_wb_sel;
  logic        dec_branch;
  logic        dec_illegal;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;

  logic [SB_DEPTH-1:0] sb_v;
  logic [4:0]          sb_rd [SB_DEPTH];

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = hold_valid & ~hazard;
  assign in_ready  = ~flush & (~hold_valid | out_fire);

  assign opcode    = in_instruction[6:0];
  assign funct3    = in_instruction[14:12];
  assign imm_i     = {{20{in_instruction[31]}}, in_instruction[31:20]};
  assign imm_s     = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
  assign imm_b     = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                      in_instruction[30:25], in_instruction[11:8], 1'b0};
  assign imm_j     = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                      in_instruction[20], in_instruction[30:21], 1'b0};
  assign imm_u     = {in_instruction[31:12], 12'b0};
  // funct7[5] selects the alternate ALU group (sub / sra)
  assign alu_arith = {2'b00, in_instruction[30], funct3};

  always_comb begin
    dec_alu      = 6'd0;
    dec_op_a     = 2'b00;
    dec_op_b     = 1'b0;
    dec_imm      = 32'd0;
    dec_wen      = 1'b0;
    dec_mem_wen  = 1'b0;
    dec_wb_sel   = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;
    dec_uses_rs1 = 1'b1;
    dec_uses_rs2 = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec_alu      = alu_arith;
        dec_op_b     = 1'b1;
        dec_wen      = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        dec_alu = alu_arith;
        dec_imm = imm_i;
        dec_wen = 1'b1;
      end
      OP_LOAD: begin
        dec_alu    = {3'b000, funct3};
        dec_imm    = imm_i;
        dec_wen    = 1'b1;
        dec_wb_sel = 1'b1;
      end
      OP_STORE: begin
        dec_alu      = {3'b000, funct3};
        dec_imm      = imm_s;
        dec_mem_wen  = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_alu      = {3'b010, funct3};
        dec_op_b     = 1'b1;
        dec_imm      = imm_b;
        dec_branch   = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_alu      = 6'b011111;
        dec_op_a     = 2'b10;
        dec_imm      = imm_j;
        dec_wen      = 1'b1;
        dec_branch   = 1'b1;
        dec_uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec_alu    = 6'b111111;
        dec_imm    = imm_i;
        dec_wen    = 1'b1;
        dec_branch = 1'b1;
      end
      OP_AUIPC: begin
        dec_op_a     = 2'b01;
        dec_imm      = imm_u;
        dec_wen      = 1'b1;
        dec_uses_rs1 = 1'b0;
      end
      OP_LUI: begin
        dec_imm      = imm_u;
        dec_wen      = 1'b1;
        dec_uses_rs1 = 1'b0;
      end
      default: begin
        dec_imm     = imm_i;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Held instruction only changes on acceptance, so outputs stay put while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid  <= 1'b0;
      out_PC      <= '0;
      read_sel1   <= 5'd0;
      read_sel2   <= 5'd0;
      write_sel   <= 5'd0;
      wEn         <= 1'b0;
      mem_wEn     <= 1'b0;
      wb_sel      <= 1'b0;
      branch_op   <= 1'b0;
      op_B_sel    <= 1'b0;
      op_A_sel    <= 2'b00;
      ALU_Control <= 6'd0;
      imm32       <= 32'd0;
      illegal     <= 1'b0;
      uses_rs1    <= 1'b0;
      uses_rs2    <= 1'b0;
    end else begin
      if (in_fire) begin
        hold_valid  <= 1'b1;
        out_PC      <= in_PC;
        read_sel1   <= in_instruction[19:15];
        read_sel2   <= in_instruction[24:20];
        write_sel   <= in_instruction[11:7];
        wEn         <= dec_wen;
        mem_wEn     <= dec_mem_wen;
        wb_sel      <= dec_wb_sel;
        branch_op   <= dec_branch;
        op_B_sel    <= dec_op_b;
        op_A_sel    <= dec_op_a;
        ALU_Control <= dec_alu;
        imm32       <= dec_imm;
        illegal     <= dec_illegal;
        uses_rs1    <= dec_uses_rs1;
        uses_rs2    <= dec_uses_rs2;
      end else if (flush || out_fire) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Loads leaving for execute are tracked until their result is written back.
  assign sb_load_v = out_fire & wb_sel & wEn & (write_sel != 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_v <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_rd[i] <= 5'd0;
      end
    end else begin
      sb_v[0]  <= sb_load_v;
      sb_rd[0] <= write_sel;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (hold_valid && sb_v[i] && (sb_rd[i] != 5'd0)) begin
        if (uses_rs1 && (sb_rd[i] == read_sel1)) begin
          hazard = 1'b1;
        end
        if (uses_rs2 && (sb_rd[i] == read_sel2)) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random instruction streams,
// checked by a cycle-level reference model and a decoupled output scoreboard.
module tb_decode_stage;

  localparam int ADDRESS_BITS = 16;
  localparam int SB_DEPTH     = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_BITS-1:0] in_PC;
  logic [31:0]             in_instruction;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_BITS-1:0] out_PC;
  logic [4:0]              read_sel1;
  logic [4:0]              read_sel2;
  logic [4:0]              write_sel;
  logic                    wEn;
  logic                    mem_wEn;
  logic                    wb_sel;
  logic                    branch_op;
  logic                    op_B_sel;
  logic [1:0]              op_A_sel;
  logic [5:0]              ALU_Control;
  logic [31:0]             imm32;
  logic                    illegal;

  decode_stage #(.ADDRESS_BITS(ADDRESS_BITS), .SB_DEPTH(SB_DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_PC(in_PC), .in_instruction(in_instruction), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .mem_wEn(mem_wEn), .wb_sel(wb_sel), .branch_op(branch_op),
    .op_B_sel(op_B_sel), .op_A_sel(op_A_sel), .ALU_Control(ALU_Control),
    .imm32(imm32), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [76:0] obs;
    bit          use1;
    bit          use2;
    bit          is_load;
    int          rs1;
    int          rs2;
    int          rd;
  } ref_t;

  logic [76:0] dut_obs;
  assign dut_obs = {out_PC, read_sel1, read_sel2, write_sel, wEn, mem_wEn, wb_sel,
                    branch_op, op_B_sel, op_A_sel, ALU_Control, imm32, illegal};

  int   tests;
  int   fails;
  int   cyc;
  int   ready_at [32];
  bit   held;
  ref_t held_rec;
  ref_t exp_q [$];
  bit   m_in_ready;
  bit   m_out_valid;
  bit   m_in_fire;
  bit   m_out_fire;
  bit   m_hazard;

  task automatic check_output(input string name, input logic [76:0] got, input logic [76:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Immediates are rebuilt as plain signed arithmetic on the bit weights.
  function automatic ref_t decode_ref(input logic [31:0] ins, input logic [15:0] pc);
    ref_t r;
    int op, f3, imm, alu, opa;
    bit wen, mwen, wb, br, opb, ill;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    wen = 0; mwen = 0; wb = 0; br = 0; opb = 0; ill = 0; alu = 0; opa = 0;
    imm = int'(ins[31:20]);
    if (imm >= 2048) imm -= 4096;
    r.use1 = 1;
    r.use2 = 0;
    case (op)
      'h33: begin alu = (ins[30] ? 8 : 0) + f3; opb = 1; wen = 1; imm = 0; r.use2 = 1; end
      'h13: begin alu = (ins[30] ? 8 : 0) + f3; wen = 1; end
      'h03: begin alu = f3; wen = 1; wb = 1; end
      'h23: begin
        alu = f3; mwen = 1; r.use2 = 1;
        imm = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (imm >= 2048) imm -= 4096;
      end
      'h63: begin
        alu = 16 + f3; opb = 1; br = 1; r.use2 = 1;
        imm = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) imm -= 4096;
      end
      'h6F: begin
        alu = 31; opa = 2; wen = 1; br = 1; r.use1 = 0;
        imm = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) imm -= 1048576;
      end
      'h67: begin alu = 63; wen = 1; br = 1; end
      'h17: begin opa = 1; wen = 1; imm = int'(32'(ins[31:12]) * 32'd4096); r.use1 = 0; end
      'h37: begin wen = 1; imm = int'(32'(ins[31:12]) * 32'd4096); r.use1 = 0; end
      default: ill = 1;
    endcase
    r.is_load = (op == 'h03);
    r.rs1 = int'(ins[19:15]);
    r.rs2 = int'(ins[24:20]);
    r.rd  = int'(ins[11:7]);
    r.obs = {pc, ins[19:15], ins[24:20], ins[11:7], wen, mwen, wb, br, opb,
             2'(opa), 6'(alu), 32'(imm), ill};
    return r;
  endfunction

  // Expected handshake for the current cycle, from register readiness times.
  always @(negedge clock) begin
    if (reset) begin
      m_out_valid = 0;
      m_out_fire  = 0;
      m_in_ready  = !flush;
      m_in_fire   = 0;
      check_output("reset_illegal", 77'(illegal), 77'(0));
    end else begin
      m_hazard = 0;
      if (held) begin
        if (held_rec.use1 && held_rec.rs1 != 0 && ready_at[held_rec.rs1] > cyc) m_hazard = 1;
        if (held_rec.use2 && held_rec.rs2 != 0 && ready_at[held_rec.rs2] > cyc) m_hazard = 1;
      end
      m_out_valid = held && !m_hazard;
      m_out_fire  = m_out_valid && out_ready;
      m_in_ready  = !flush && (!held || m_out_fire);
      m_in_fire   = in_valid && m_in_ready;
    end
    check_output("out_valid", 77'(out_valid), 77'(m_out_valid));
    check_output("in_ready", 77'(in_ready), 77'(m_in_ready));
  end

  always @(posedge clock) begin
    if (reset) begin
      held = 0;
      exp_q.delete();
      foreach (ready_at[i]) ready_at[i] = 0;
    end else begin
      if (m_out_fire && held_rec.is_load && held_rec.rd != 0)
        ready_at[held_rec.rd] = cyc + SB_DEPTH + 1;
      if (flush && held && !m_out_fire && exp_q.size() > 0)
        void'(exp_q.pop_back());
      if (m_in_fire) begin
        held_rec = decode_ref(in_instruction, in_PC);
        held = 1;
        exp_q.push_back(held_rec);
      end else if (flush || m_out_fire) begin
        held = 0;
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL monitor_unexpected: got out_valid 1 expected no held instruction");
      end else begin
        check_output("decode", dut_obs, exp_q[0].obs);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_to_negedge(input bit ordy);
    in_valid  = 0;
    flush     = 0;
    out_ready = ordy;
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic [31:0] ins, input bit random_ctl);
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      in_valid       = 1;
      in_instruction = ins;
      in_PC          = 16'($urandom);
      if (random_ctl) begin
        flush     = ($urandom_range(0, 9) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        flush     = 0;
        out_ready = 1;
      end
      @(negedge clock);
      done = m_in_fire;
      next_cycle();
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no acceptance expected acceptance within 100 cycles");
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h17, 7'h37, 7'h7F, 7'h73, 7'h0F};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    int stall;
    bit seen;
    tests = 0; fails = 0; cyc = 0; held = 0;
    reset = 1; in_valid = 0; in_instruction = 0; in_PC = 0; flush = 0; out_ready = 0;
    @(posedge clock);
    next_cycle();
    reset = 0;
    idle_to_negedge(1);
    check_output("reset_out_valid", 77'(out_valid), 77'(0));
    next_cycle();

    // addi x1,x0,5
    apply_stimulus(32'h00500093, 0);
    idle_to_negedge(1);
    check_output("addi_valid", 77'(out_valid), 77'(1));
    check_output("addi_alu", 77'(ALU_Control), 77'(0));
    check_output("addi_opb", 77'(op_B_sel), 77'(0));
    check_output("addi_imm", 77'(imm32), 77'(5));
    check_output("addi_wen", 77'(wEn), 77'(1));
    check_output("addi_rd", 77'(write_sel), 77'(1));
    next_cycle();

    // lw x2,0(x1) then dependent add x3,x2,x1
    apply_stimulus(32'h0000A103, 0);
    apply_stimulus(32'h001101B3, 0);
    stall = 0;
    seen  = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      idle_to_negedge(1);
      if (out_valid) begin
        seen = 1;
        check_output("loaduse_alu", 77'(ALU_Control), 77'(0));
        check_output("loaduse_rs1", 77'(read_sel1), 77'(2));
      end else begin
        stall++;
      end
      next_cycle();
    end
    check_output("loaduse_stall", 77'(stall), 77'(SB_DEPTH));

    // lw x0 never blocks a following reader of x0
    apply_stimulus(32'h0000A003, 0);
    apply_stimulus(32'h001001B3, 0);
    idle_to_negedge(1);
    check_output("x0_no_stall", 77'(out_valid), 77'(1));
    next_cycle();

    // beq x1,x2,-8 then flush with a younger instruction offered
    apply_stimulus(32'hFE208CE3, 0);
    in_valid = 1; in_instruction = 32'h00700293; flush = 1; out_ready = 1;
    @(negedge clock);
    check_output("beq_branch", 77'(branch_op), 77'(1));
    check_output("beq_alu", 77'(ALU_Control), 77'(6'b010000));
    check_output("beq_imm", 77'(imm32), 77'(32'hFFFFFFF8));
    check_output("flush_in_ready", 77'(in_ready), 77'(0));
    next_cycle();
    idle_to_negedge(1);
    check_output("flush_drop", 77'(out_valid), 77'(0));
    next_cycle();

    // sub x4,x1,x2 under back-pressure, then release with a waiting addi
    apply_stimulus(32'h40208233, 0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_instruction = 32'h00700293; flush = 0; out_ready = 0;
      @(negedge clock);
      check_output("bp_in_ready", 77'(in_ready), 77'(0));
      check_output("bp_alu", 77'(ALU_Control), 77'(6'b001000));
      next_cycle();
    end
    out_ready = 1;
    @(negedge clock);
    check_output("release_accept", 77'(in_ready), 77'(1));
    next_cycle();
    idle_to_negedge(1);
    next_cycle();

    // illegal opcode held under back-pressure, then reset mid-stall
    apply_stimulus(32'h0000007F, 0);
    idle_to_negedge(0);
    check_output("illegal_flag", 77'(illegal), 77'(1));
    check_output("illegal_ctrl", 77'({wEn, mem_wEn, wb_sel, branch_op, op_B_sel, op_A_sel, ALU_Control}), 77'(0));
    next_cycle();
    reset = 1;
    @(negedge clock);
    check_output("reset_async_valid", 77'(out_valid), 77'(0));
    check_output("reset_async_illegal", 77'(illegal), 77'(0));
    next_cycle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      idle_to_negedge(1);
      next_cycle();
    end

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid  = 0;
        flush     = ($urandom_range(0, 9) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        next_cycle();
      end
      apply_stimulus(rand_instr(), 1);
    end

    for (int k = 0; k < 10; k++) begin
      idle_to_negedge(1);
      next_cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
